// File: rtl/reg_scoreboard.sv
// Register busy/ready scoreboard for decode/issue.
// Tracks in-flight writers to real registers (id bit7=1) by tag, answers
// per-source readiness with same-cycle writeback bypass, and drives the
// issue stall. Fake ids (bit7=0) and out-of-range real ids are always ready.
module reg_scoreboard #(
  parameter int NUM_REGS = 18,
  parameter int NUM_SRC  = 3,
  parameter int TAG_W    = 4,
  parameter int ID_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          issue_valid,
  input  logic                          issue_has_dst,
  input  logic [ID_W-1:0]               issue_dst_id,
  input  logic [TAG_W-1:0]              issue_tag,
  input  logic [NUM_SRC*ID_W-1:0]       issue_src_id,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          issue_stall,
  input  logic                          wb_valid,
  input  logic [ID_W-1:0]               wb_dst_id,
  input  logic [TAG_W-1:0]              wb_tag,
  input  logic                          flush,
  output logic [NUM_REGS-1:0]           busy_vec,
  output logic [$clog2(NUM_REGS+1)-1:0] busy_count,
  output logic                          err_bad_id
);

  localparam int IDX_W = ID_W - 1;
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic [NUM_REGS-1:0] r_busy;
  logic [TAG_W-1:0]    r_tag [NUM_REGS];
  logic [CNT_W-1:0]    r_busy_count;
  logic                r_err_bad_id;

  logic [NUM_REGS-1:0] w_busy_next;
  logic [TAG_W-1:0]    w_tag_next [NUM_REGS];
  logic [CNT_W-1:0]    w_count_next;
  logic                w_err_next;
  logic [NUM_SRC-1:0]  w_src_ready;
  logic                w_stall;
  logic                w_accept;

  function automatic logic is_valid_real(input logic [ID_W-1:0] id);
    return id[ID_W-1] && (32'(id[IDX_W-1:0]) < NUM_REGS);
  endfunction

  function automatic logic is_bad_real(input logic [ID_W-1:0] id);
    return id[ID_W-1] && !(32'(id[IDX_W-1:0]) < NUM_REGS);
  endfunction

  // True when id names tracked register i.
  function automatic logic hits(input logic [ID_W-1:0] id, input int i);
    return is_valid_real(id) && (id[IDX_W-1:0] == IDX_W'(i));
  endfunction

  // Per-source readiness: a busy register is still ready when its own
  // writer is completing this cycle (bypass).
  always_comb begin
    // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
    w_src_ready = '1;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hits(issue_src_id[k*ID_W +: ID_W], i) && r_busy[i] &&
            !(wb_valid && (wb_dst_id == issue_src_id[k*ID_W +: ID_W]) &&
              (wb_tag == r_tag[i]))) begin
          w_src_ready[k] = 1'b0;
        end
      end
    end
  end

  assign w_stall     = issue_valid && !flush && !(&w_src_ready);
  assign w_accept    = issue_valid && !w_stall && !flush;
  assign src_ready   = w_src_ready;
  assign issue_stall = w_stall;

  // Next busy/tag state: writeback clear first, issue set overrides it,
  // flush overrides everything.
  always_comb begin
    w_busy_next = r_busy;
    w_tag_next  = r_tag;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_valid && hits(wb_dst_id, i) && r_busy[i] && (wb_tag == r_tag[i])) begin
        w_busy_next[i] = 1'b0;
      end
      if (w_accept && issue_has_dst && hits(issue_dst_id, i)) begin
        w_busy_next[i] = 1'b1;
        w_tag_next[i]  = issue_tag;
      end
    end
    if (flush) begin
      w_busy_next = '0;
    end
  end

  // Popcount of the next busy vector so the count lands on the same edge.
  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_count_next = w_count_next + CNT_W'(w_busy_next[i]);
    end
  end

  // Bad-id detection on any presented src/dst or writeback id; independent of flush.
  always_comb begin
    w_err_next = wb_valid && is_bad_real(wb_dst_id);
    if (issue_valid) begin
      if (issue_has_dst && is_bad_real(issue_dst_id)) begin
        w_err_next = 1'b1;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
        if (is_bad_real(issue_src_id[k*ID_W +: ID_W])) begin
          w_err_next = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      r_err_bad_id <= 1'b0;
      // NOTE: the tag array is small flop storage, not a RAM, so resetting it is cheap and keeps state deterministic.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      r_busy       <= w_busy_next;
      r_tag        <= w_tag_next;
      r_busy_count <= w_count_next;
      r_err_bad_id <= w_err_next;
    end
  end

  assign busy_vec   = r_busy;
  assign busy_count = r_busy_count;
  assign err_bad_id = r_err_bad_id;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus a random
// phase, all checked against a tag-tracking reference model.
module tb_reg_scoreboard;

  localparam int NR = 18;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_has_dst;
  logic [7:0]  issue_dst_id;
  logic [3:0]  issue_tag;
  logic [23:0] issue_src_id;
  logic [2:0]  src_ready;
  logic        issue_stall;
  logic        wb_valid;
  logic [7:0]  wb_dst_id;
  logic [3:0]  wb_tag;
  logic        flush;
  logic [NR-1:0] busy_vec;
  logic [4:0]  busy_count;
  logic        err_bad_id;

  int total = 0;
  int bad   = 0;

  // Reference model: which registers have an outstanding writer and its tag.
  bit       m_busy [NR];
  bit [3:0] m_tag  [NR];

  reg_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_has_dst(issue_has_dst),
    .issue_dst_id(issue_dst_id), .issue_tag(issue_tag),
    .issue_src_id(issue_src_id), .src_ready(src_ready),
    .issue_stall(issue_stall), .wb_valid(wb_valid),
    .wb_dst_id(wb_dst_id), .wb_tag(wb_tag), .flush(flush),
    .busy_vec(busy_vec), .busy_count(busy_count), .err_bad_id(err_bad_id)
  );

  always #5 clk = ~clk;

  // 0 = fake, 1 = valid real, 2 = invalid real
  function automatic int cls(input logic [7:0] id);
    if (!id[7]) return 0;
    if (int'(id[6:0]) < NR) return 1;
    return 2;
  endfunction

  function automatic bit model_ready(input logic [7:0] id);
    int idx;
    if (cls(id) != 1) return 1'b1;
    idx = int'(id[6:0]);
    if (!m_busy[idx]) return 1'b1;
    return wb_valid && (wb_dst_id == id) && (wb_tag == m_tag[idx]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_busy[i] = 1'b0;
      m_tag[i]  = 4'd0;
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_has_dst = 1'b0; issue_dst_id = 8'h00;
    issue_tag = 4'd0; issue_src_id = 24'h0;
    wb_valid = 1'b0; wb_dst_id = 8'h00; wb_tag = 4'd0; flush = 1'b0;
  endtask

  task automatic set_issue(input logic v, input logic hd, input logic [7:0] d,
                           input logic [3:0] t, input logic [7:0] s0,
                           input logic [7:0] s1, input logic [7:0] s2);
    issue_valid = v; issue_has_dst = hd; issue_dst_id = d; issue_tag = t;
    issue_src_id = {s2, s1, s0};
  endtask

  task automatic set_wb(input logic v, input logic [7:0] d, input logic [3:0] t);
    wb_valid = v; wb_dst_id = d; wb_tag = t;
  endtask

  // One clock: check combinational outputs, advance the model, check
  // registered outputs just after the edge. Entered shortly after a posedge.
  task automatic do_cycle(input string name);
    logic [2:0]    exp_rdy;
    logic          exp_stall, exp_err, accept;
    bit            nb [NR];
    bit [3:0]      nt [NR];
    logic [NR-1:0] exp_vec;
    int            exp_cnt;
    #1;
    for (int k = 0; k < 3; k++) exp_rdy[k] = model_ready(issue_src_id[k*8 +: 8]);
    exp_stall = issue_valid && !flush && (exp_rdy != 3'b111);
    total++;
    if (src_ready !== exp_rdy) begin
      bad++; $display("FAIL %s src_ready got=%b exp=%b", name, src_ready, exp_rdy);
    end
    total++;
    if (issue_stall !== exp_stall) begin
      bad++; $display("FAIL %s issue_stall got=%b exp=%b", name, issue_stall, exp_stall);
    end
    accept  = issue_valid && !exp_stall && !flush;
    exp_err = (wb_valid && cls(wb_dst_id) == 2) ||
              (issue_valid && ((issue_has_dst && cls(issue_dst_id) == 2) ||
                               cls(issue_src_id[7:0]) == 2 ||
                               cls(issue_src_id[15:8]) == 2 ||
                               cls(issue_src_id[23:16]) == 2));
    nb = m_busy;
    nt = m_tag;
    if (flush) begin
      for (int i = 0; i < NR; i++) nb[i] = 1'b0;
    end else begin
      if (wb_valid && cls(wb_dst_id) == 1 && m_busy[int'(wb_dst_id[6:0])] &&
          m_tag[int'(wb_dst_id[6:0])] == wb_tag)
        nb[int'(wb_dst_id[6:0])] = 1'b0;
      if (accept && issue_has_dst && cls(issue_dst_id) == 1) begin
        nb[int'(issue_dst_id[6:0])] = 1'b1;
        nt[int'(issue_dst_id[6:0])] = issue_tag;
      end
    end
    @(posedge clk);
    #1;
    m_busy  = nb;
    m_tag   = nt;
    exp_cnt = 0;
    for (int i = 0; i < NR; i++) begin
      exp_vec[i] = m_busy[i];
      exp_cnt += int'(m_busy[i]);
    end
    total++;
    if (busy_vec !== exp_vec) begin
      bad++; $display("FAIL %s busy_vec got=%h exp=%h", name, busy_vec, exp_vec);
    end
    total++;
    if (busy_count !== 5'(exp_cnt)) begin
      bad++; $display("FAIL %s busy_count got=%0d exp=%0d", name, busy_count, exp_cnt);
    end
    total++;
    if (err_bad_id !== exp_err) begin
      bad++; $display("FAIL %s err_bad_id got=%b exp=%b", name, err_bad_id, exp_err);
    end
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    model_clear();
    set_issue(1'b1, 1'b0, 8'h00, 4'd0, 8'h80, 8'h81, 8'h85);
    #12;
    total++;
    if (busy_vec !== '0 || busy_count !== 5'd0 || err_bad_id !== 1'b0) begin
      bad++; $display("FAIL reset_regs vec=%h cnt=%0d err=%b exp vec=0 cnt=0 err=0",
                      busy_vec, busy_count, err_bad_id);
    end
    total++;
    if (src_ready !== 3'b111 || issue_stall !== 1'b0) begin
      bad++; $display("FAIL reset_comb rdy=%b stall=%b exp rdy=111 stall=0", src_ready, issue_stall);
    end
    idle();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    idle(); set_issue(1'b1, 1'b1, 8'h80, 4'd3, 8'h00, 8'h01, 8'h02);
    do_cycle("issue_rax");
    total++;
    if (busy_vec[0] !== 1'b1 || busy_count !== 5'd1) begin
      bad++; $display("FAIL rax_busy bit=%b cnt=%0d exp bit=1 cnt=1", busy_vec[0], busy_count);
    end
    idle(); set_issue(1'b1, 1'b0, 8'h00, 4'd0, 8'h80, 8'h00, 8'h00);
    #1;
    total++;
    if (src_ready !== 3'b110 || issue_stall !== 1'b1) begin
      bad++; $display("FAIL rax_stall rdy=%b stall=%b exp rdy=110 stall=1", src_ready, issue_stall);
    end
    do_cycle("read_rax_stall");
  endtask

  task automatic test_bypass();
    idle();
    set_wb(1'b1, 8'h80, 4'd3);
    set_issue(1'b1, 1'b1, 8'h84, 4'd7, 8'h80, 8'h00, 8'h00);
    #1;
    total++;
    if (src_ready !== 3'b111 || issue_stall !== 1'b0) begin
      bad++; $display("FAIL bypass rdy=%b stall=%b exp rdy=111 stall=0", src_ready, issue_stall);
    end
    do_cycle("bypass");
    total++;
    if (busy_vec[0] !== 1'b0 || busy_vec[4] !== 1'b1) begin
      bad++; $display("FAIL bypass_after rax=%b r4=%b exp rax=0 r4=1", busy_vec[0], busy_vec[4]);
    end
    idle(); set_wb(1'b1, 8'h84, 4'd7);
    do_cycle("wb_r4");
  endtask

  task automatic test_waw();
    idle(); set_issue(1'b1, 1'b1, 8'h83, 4'd1, 8'h00, 8'h00, 8'h00); do_cycle("waw_t1");
    idle(); set_issue(1'b1, 1'b1, 8'h83, 4'd2, 8'h00, 8'h00, 8'h00); do_cycle("waw_t2");
    idle(); set_wb(1'b1, 8'h83, 4'd1); do_cycle("waw_wb_stale");
    total++;
    if (busy_vec[3] !== 1'b1) begin
      bad++; $display("FAIL waw_stale busy3 got=%b exp=1", busy_vec[3]);
    end
    idle(); set_wb(1'b1, 8'h83, 4'd2); do_cycle("waw_wb_new");
    total++;
    if (busy_vec[3] !== 1'b0) begin
      bad++; $display("FAIL waw_new busy3 got=%b exp=0", busy_vec[3]);
    end
  endtask

  task automatic test_same_cycle();
    idle(); set_issue(1'b1, 1'b1, 8'h81, 4'd4, 8'h00, 8'h00, 8'h00); do_cycle("sc_first");
    idle(); set_issue(1'b1, 1'b1, 8'h81, 4'd5, 8'h00, 8'h00, 8'h00);
    set_wb(1'b1, 8'h81, 4'd4); do_cycle("sc_issue_wins");
    total++;
    if (busy_vec[1] !== 1'b1) begin
      bad++; $display("FAIL sc_issue_wins busy1 got=%b exp=1", busy_vec[1]);
    end
    idle(); set_wb(1'b1, 8'h81, 4'd4); do_cycle("sc_old_tag");
    idle(); set_wb(1'b1, 8'h81, 4'd5); do_cycle("sc_tag5");
    total++;
    if (busy_vec[1] !== 1'b0) begin
      bad++; $display("FAIL sc_tag5 busy1 got=%b exp=0", busy_vec[1]);
    end
  endtask

  task automatic test_fake_invalid();
    idle(); set_issue(1'b1, 1'b1, 8'h82, 4'd9, 8'h00, 8'h00, 8'h00); do_cycle("fi_busy_r2");
    idle(); set_issue(1'b1, 1'b0, 8'h00, 4'd0, 8'h01, 8'h02, 8'h00); do_cycle("fi_fake_src");
    idle(); set_issue(1'b1, 1'b1, 8'h92, 4'd6, 8'h01, 8'h02, 8'h00); do_cycle("fi_bad_dst");
    total++;
    if (err_bad_id !== 1'b1 || busy_vec !== 18'h00004) begin
      bad++; $display("FAIL fi_bad_dst err=%b vec=%h exp err=1 vec=00004", err_bad_id, busy_vec);
    end
    idle(); do_cycle("fi_err_drop");
    total++;
    if (err_bad_id !== 1'b0) begin
      bad++; $display("FAIL fi_err_pulse err got=%b exp=0", err_bad_id);
    end
    idle(); set_issue(1'b1, 1'b0, 8'h00, 4'd0, 8'hA0, 8'h82, 8'h00); do_cycle("fi_bad_src");
    idle(); set_issue(1'b0, 1'b0, 8'h00, 4'd0, 8'hFF, 8'h00, 8'h00); do_cycle("fi_bad_noissue");
    idle(); set_wb(1'b1, 8'h95, 4'd0); do_cycle("fi_bad_wb");
    idle(); set_wb(1'b1, 8'h82, 4'd9); do_cycle("fi_clear_r2");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      idle(); set_issue(1'b1, 1'b1, 8'h85 + 8'(i), 4'(i + 8), 8'h00, 8'h00, 8'h00);
      do_cycle("fl_fill");
    end
    total++;
    if (busy_count !== 5'd5) begin
      bad++; $display("FAIL fl_fill busy_count got=%0d exp=5", busy_count);
    end
    idle(); flush = 1'b1;
    set_issue(1'b1, 1'b1, 8'h8A, 4'd1, 8'h85, 8'h00, 8'h00);
    set_wb(1'b1, 8'h86, 4'd9);
    do_cycle("fl_flush");
    total++;
    if (busy_vec !== '0 || busy_count !== 5'd0) begin
      bad++; $display("FAIL fl_flush vec=%h cnt=%0d exp vec=0 cnt=0", busy_vec, busy_count);
    end
    idle(); set_issue(1'b1, 1'b1, 8'h80, 4'd2, 8'h00, 8'h00, 8'h00); do_cycle("fl_reissue");
    idle(); set_issue(1'b1, 1'b1, 8'h92, 4'd2, 8'h80, 8'h00, 8'h00);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (busy_vec !== '0 || busy_count !== 5'd0 || err_bad_id !== 1'b0 ||
        src_ready !== 3'b111 || issue_stall !== 1'b0) begin
      bad++; $display("FAIL mid_reset vec=%h cnt=%0d err=%b rdy=%b stall=%b exp 0/0/0/111/0",
                      busy_vec, busy_count, err_bad_id, src_ready, issue_stall);
    end
    idle();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    do_cycle("post_reset_idle");
  endtask

  function automatic logic [7:0] rand_id();
    int r = int'($urandom_range(0, 9));
    if (r <= 6) return 8'h80 + 8'($urandom_range(0, NR - 1));
    if (r <= 8) return 8'($urandom_range(0, 2));
    return 8'($urandom_range(8'h92, 8'hFF));
  endfunction

  task automatic test_random();
    logic [7:0] d, w;
    logic       hd;
    for (int n = 0; n < 400; n++) begin
      idle();
      hd = 1'($urandom_range(0, 1));
      d  = hd ? rand_id() : 8'h00;
      set_issue(1'($urandom_range(0, 3) != 0), hd, d, 4'($urandom),
                rand_id(), rand_id(), rand_id());
      if ($urandom_range(0, 2) != 0) begin
        w = rand_id();
        if (cls(w) == 1 && $urandom_range(0, 3) != 0)
          set_wb(1'b1, w, m_tag[int'(w[6:0])]);
        else
          set_wb(1'b1, w, 4'($urandom));
      end
      flush = ($urandom_range(0, 24) == 0);
      do_cycle("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_waw();
    test_same_cycle();
    test_fake_invalid();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
